// File: rtl/reg_wb_arbiter_if.sv
// Writeback-arbiter bundle: two writeback requesters, the reservation port, the read-hazard
// lookup and the register-bank write port.
interface reg_wb_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  localparam int NREG = 2 ** AW;

  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [DW-1:0]   req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [DW-1:0]   req1_data;
  logic            req1_ready;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic            hazard;
  logic [NREG-1:0] busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
           rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    input  req0_ready, req1_ready, rsv_ready, hazard, busy, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
           rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    output req0_ready, req1_ready, rsv_ready, hazard, busy, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the register-bank write port (ALU vs load path) with per-register
// pending-write counters that drive busy and read-hazard flags.
module reg_wb_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 2
) (
  input  logic              clk,
  input  logic              rst,
  reg_wb_arbiter_if.slave   bus
);
  localparam int NREG = 2 ** AW;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic            gnt0_s;
  logic            gnt1_s;
  logic            xfer_s;
  logic [AW-1:0]   xfer_addr_s;
  logic [DW-1:0]   xfer_data_s;
  logic            rsv_ready_s;
  logic [NREG-1:0] busy_s;
  logic [NREG-1:0] inc_s;
  logic [NREG-1:0] dec_s;
  logic [CW-1:0]   pend_cnt_nxt_s [NREG];
  logic [CW-1:0]   pend_cnt_r     [NREG];
  logic            last_grant_r;
  logic            wr_en_r;
  logic [AW-1:0]   wr_addr_r;
  logic [DW-1:0]   wr_data_r;

  // Grant selection: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (last_grant_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (bus.req0_valid) begin
      gnt0_s = 1'b1;
    end else if (bus.req1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Transfer payload mux.
  always_comb begin
    xfer_s      = gnt0_s | gnt1_s;
    xfer_addr_s = {AW{1'b0}};
    xfer_data_s = {DW{1'b0}};
    if (gnt1_s) begin
      xfer_addr_s = bus.req1_addr;
      xfer_data_s = bus.req1_data;
    end else begin
      xfer_addr_s = bus.req0_addr;
      xfer_data_s = bus.req0_data;
    end
  end

  // Pending counters: reserve increments, write transfer decrements, both together cancel.
  always_comb begin
    rsv_ready_s = (pend_cnt_r[bus.rsv_addr] != CNT_MAX);
    for (int i = 0; i < NREG; i++) begin
      busy_s[i] = (pend_cnt_r[i] != {CW{1'b0}});
      inc_s[i]  = bus.rsv_valid && rsv_ready_s && (bus.rsv_addr == AW'(i));
      dec_s[i]  = xfer_s && (xfer_addr_s == AW'(i));
      if (inc_s[i] && !dec_s[i]) begin
        pend_cnt_nxt_s[i] = pend_cnt_r[i] + CW'(1'b1);
      end else if (!inc_s[i] && dec_s[i] && busy_s[i]) begin
        pend_cnt_nxt_s[i] = pend_cnt_r[i] - CW'(1'b1);
      end else begin
        pend_cnt_nxt_s[i] = pend_cnt_r[i];
      end
    end
  end

  // Pending counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        pend_cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      pend_cnt_r <= pend_cnt_nxt_s;
    end
  end

  // Bank write register and round-robin history; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {AW{1'b0}};
      wr_data_r    <= {DW{1'b0}};
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      wr_en_r      <= 1'b1;
      wr_addr_r    <= xfer_addr_s;
      wr_data_r    <= xfer_data_s;
      last_grant_r <= gnt1_s;
    end else begin
      wr_en_r      <= 1'b0;
    end
  end

  assign bus.req0_ready = gnt0_s;
  assign bus.req1_ready = gnt1_s;
  assign bus.rsv_ready  = rsv_ready_s;
  assign bus.busy       = busy_s;
  assign bus.hazard     = busy_s[bus.rd_addr1] | busy_s[bus.rd_addr2];
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector table for reg_wb_arbiter plus a hand-written asynchronous-reset sequence.
module tb_reg_wb_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  reg_wb_arbiter_if #(.DW(8), .AW(3)) bus ();

  reg_wb_arbiter #(.DW(8), .AW(3), .CW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       r0v;
    logic [2:0] r0a;
    logic [7:0] r0d;
    logic       r1v;
    logic [2:0] r1a;
    logic [7:0] r1d;
    logic       sv;
    logic [2:0] sa;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       e_r0;
    logic       e_r1;
    logic       e_rs;
    logic       e_hz;
    logic [7:0] e_busy;
    logic       e_we;
    logic [2:0] e_wa;
    logic [7:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r0v, input logic [2:0] r0a, input logic [7:0] r0d,
                     input logic r1v, input logic [2:0] r1a, input logic [7:0] r1d,
                     input logic sv, input logic [2:0] sa, input logic [2:0] a1, input logic [2:0] a2,
                     input logic e_r0, input logic e_r1, input logic e_rs, input logic e_hz,
                     input logic [7:0] e_busy, input logic e_we, input logic [2:0] e_wa,
                     input logic [7:0] e_wd);
    vec_t v;
    v = '{r0v, r0a, r0d, r1v, r1a, r1d, sv, sa, a1, a2, e_r0, e_r1, e_rs, e_hz, e_busy, e_we, e_wa, e_wd};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_addr = 3'd0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_addr = 3'd0; bus.req1_data = 8'h00;
    bus.rsv_valid  = 1'b0; bus.rsv_addr  = 3'd0;
    bus.rd_addr1   = 3'd0; bus.rd_addr2  = 3'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive_idle();

    //   r0v  r0a   r0d   r1v  r1a   r1d   sv   sa    a1    a2    er0  er1  ers  ehz  busy   we   wa    wd
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,3'd0,8'h00);
    add(1'b1,3'd1,8'h11,1'b1,3'd2,8'h22,1'b0,3'd0,3'd0,3'd0,1'b1,1'b0,1'b1,1'b0,8'h00,1'b0,3'd0,8'h00);
    add(1'b1,3'd3,8'h33,1'b1,3'd2,8'h22,1'b0,3'd0,3'd0,3'd0,1'b0,1'b1,1'b1,1'b0,8'h00,1'b1,3'd1,8'h11);
    add(1'b1,3'd3,8'h33,1'b1,3'd4,8'h44,1'b0,3'd0,3'd0,3'd0,1'b1,1'b0,1'b1,1'b0,8'h00,1'b1,3'd2,8'h22);
    add(1'b1,3'd5,8'h55,1'b1,3'd4,8'h44,1'b0,3'd0,3'd0,3'd0,1'b0,1'b1,1'b1,1'b0,8'h00,1'b1,3'd3,8'h33);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,3'd4,8'h44);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,3'd4,8'h44);
    add(1'b1,3'd3,8'hA5,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b1,1'b0,1'b1,1'b0,8'h00,1'b0,3'd4,8'h44);
    add(1'b0,3'd0,8'h00,1'b1,3'd6,8'h5A,1'b0,3'd0,3'd0,3'd0,1'b0,1'b1,1'b1,1'b0,8'h00,1'b1,3'd3,8'hA5);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd5,3'd5,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd5,3'd5,3'd0,1'b0,1'b0,1'b1,1'b1,8'h20,1'b0,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd5,3'd0,3'd5,1'b0,1'b0,1'b1,1'b1,8'h20,1'b0,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd5,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,8'h20,1'b0,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd2,3'd2,3'd3,1'b0,1'b0,1'b1,1'b0,8'h20,1'b0,3'd6,8'h5A);
    add(1'b1,3'd2,8'h77,1'b0,3'd0,8'h00,1'b1,3'd2,3'd2,3'd0,1'b1,1'b0,1'b1,1'b1,8'h24,1'b0,3'd6,8'h5A);
    add(1'b0,3'd0,8'h00,1'b1,3'd5,8'h91,1'b0,3'd5,3'd0,3'd0,1'b0,1'b1,1'b0,1'b0,8'h24,1'b1,3'd2,8'h77);
    add(1'b0,3'd0,8'h00,1'b1,3'd5,8'h92,1'b0,3'd5,3'd0,3'd0,1'b0,1'b1,1'b1,1'b0,8'h24,1'b1,3'd5,8'h91);
    add(1'b1,3'd5,8'h93,1'b0,3'd0,8'h00,1'b0,3'd0,3'd0,3'd0,1'b1,1'b0,1'b1,1'b0,8'h24,1'b1,3'd5,8'h92);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b0,3'd0,3'd5,3'd0,1'b0,1'b0,1'b1,1'b0,8'h04,1'b1,3'd5,8'h93);
    add(1'b1,3'd2,8'h44,1'b0,3'd0,8'h00,1'b0,3'd0,3'd2,3'd0,1'b1,1'b0,1'b1,1'b1,8'h04,1'b0,3'd5,8'h93);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd4,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,3'd2,8'h44);
    add(1'b0,3'd0,8'h00,1'b0,3'd0,8'h00,1'b1,3'd4,3'd0,3'd0,1'b0,1'b0,1'b1,1'b0,8'h10,1'b0,3'd2,8'h44);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req0_valid = vecs[i].r0v; bus.req0_addr = vecs[i].r0a; bus.req0_data = vecs[i].r0d;
      bus.req1_valid = vecs[i].r1v; bus.req1_addr = vecs[i].r1a; bus.req1_data = vecs[i].r1d;
      bus.rsv_valid  = vecs[i].sv;  bus.rsv_addr  = vecs[i].sa;
      bus.rd_addr1   = vecs[i].a1;  bus.rd_addr2  = vecs[i].a2;
      #1;
      check($sformatf("row%0d req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].e_r0));
      check($sformatf("row%0d req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].e_r1));
      check($sformatf("row%0d rsv_ready", i),  32'(bus.rsv_ready),  32'(vecs[i].e_rs));
      check($sformatf("row%0d hazard", i),     32'(bus.hazard),     32'(vecs[i].e_hz));
      check($sformatf("row%0d busy", i),       32'(bus.busy),       32'(vecs[i].e_busy));
      check($sformatf("row%0d wr_en", i),      32'(bus.wr_en),      32'(vecs[i].e_we));
      check($sformatf("row%0d wr_addr", i),    32'(bus.wr_addr),    32'(vecs[i].e_wa));
      check($sformatf("row%0d wr_data", i),    32'(bus.wr_data),    32'(vecs[i].e_wd));
    end

    // Reset mid-transfer with pend_cnt[4]=2: outputs clear without a clock edge.
    @(negedge clk);
    drive_idle();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 8'hCC;
    #1;
    check("seq req0_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    drive_idle();
    check("seq pre wr_en",   32'(bus.wr_en),   32'd1);
    check("seq pre wr_addr", 32'(bus.wr_addr), 32'd1);
    check("seq pre wr_data", 32'(bus.wr_data), 32'hCC);
    check("seq pre busy",    32'(bus.busy),    32'h10);
    #1;
    rst = 1'b1;
    #1;
    check("seq rst wr_en",   32'(bus.wr_en),   32'd0);
    check("seq rst busy",    32'(bus.busy),    32'h00);
    check("seq rst wr_addr", 32'(bus.wr_addr), 32'd0);
    check("seq rst wr_data", 32'(bus.wr_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    bus.rsv_addr   = 3'd4;
    bus.rd_addr1   = 3'd4;
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd6; bus.req0_data = 8'h01;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd7; bus.req1_data = 8'h02;
    #1;
    check("post rsv_ready",  32'(bus.rsv_ready),  32'd1);
    check("post hazard",     32'(bus.hazard),     32'd0);
    check("post req0_ready", 32'(bus.req0_ready), 32'd1);
    check("post req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
